ir_queue: RTL and testbench
===========================

# ir_queue

Parametrised instruction register with a built-in prefetch queue; successor to the single-entry 16-bit `ir`. It sits between instruction fetch and decode in `s_proc`. It buffers up to DEPTH fetched instruction words behind a valid/ready handshake on each side. It presents the oldest word, with its opcode field split out, to decode, and supports a synchronous flush for branch redirects.

## Interface
- WIDTH, 16: instruction word width in bits (≥ 8).
- DEPTH, 4: queue entries; power of two, ≥ 2.
- OPW, 4: opcode field width; opcode = d_out[WIDTH-1 -: OPW]; OPW < WIDTH.
- CW: localparam = $clog2(DEPTH)+1; width of count.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous queue clear (branch redirect).
- in_valid  in  1  fetch offers d_in.
- in_ready  out  1  queue can accept a word.
- d_in  in  WIDTH  fetched instruction word.
- out_valid  out  1  d_out holds a valid instruction.
- out_ready  in  1  decode consumes the word this cycle.
- d_out  out  WIDTH  oldest queued word (current IR contents).
- opcode  out  OPW  top OPW bits of d_out.
- count  out  CW  number of valid entries, 0..DEPTH.

## Operation
- Storage: DEPTH × WIDTH array, write pointer wp, read pointer rp (each $clog2(DEPTH) bits, wrap modulo DEPTH), occupancy register cnt (CW bits).
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- in_ready = (cnt != DEPTH). This is combinational from state only and does not depend on out_ready, so there is no pass-through when full.
- out_valid = (cnt != 0).
- d_out = mem[rp] when out_valid, else all zeros. opcode is derived from d_out, so it is 0 when empty.
- count = cnt.
- On push: mem[wp] ← d_in, wp ← wp+1.
- On pop: rp ← rp+1.
- cnt update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Simultaneous push and pop, with 0 < cnt < DEPTH: both occur and cnt holds.
- Simultaneous push and pop is impossible at cnt = 0 (out_valid = 0) and at cnt = DEPTH (in_ready = 0).
- flush = 1: wp, rp and cnt ← 0 at the edge. Flush overrides any push or pop that cycle, so the word offered that cycle is dropped. Array contents are not cleared.
- d_in is ignored when in_valid = 0 or in_ready = 0. out_ready is ignored when out_valid = 0.
- Pointer wrap: after DEPTH pushes, wp returns to 0. Order is preserved across the wrap.

## Timing
- Reset (rst = 0, asynchronous): wp = rp = cnt = 0 immediately, without waiting for clk.
- Reset output values: in_ready = 1, out_valid = 0, d_out = 0, opcode = 0, count = 0.
- Leaving reset: the first push can occur at the first rising edge with rst = 1.
- Reset asserted mid-operation discards all entries; the array contents are don't-care.
- Latency: a word pushed at edge N is on d_out (if the queue was empty) with out_valid = 1 after edge N; it can be consumed at edge N+1.
- Throughput: one push and one pop per cycle sustained when 0 < cnt < DEPTH.
- Full: in_ready falls after the edge that makes cnt = DEPTH. It rises after the edge carrying the next pop or flush.
- Empty: out_valid falls after the edge that makes cnt = 0.
- All outputs are functions of registered state; there are no combinational input→output paths.

## Test plan
- Reset defaults: hold rst = 0 for 3 cycles mid-clock with in_valid = 1, d_in = 16'h00B1 → in_ready = 1, out_valid = 0, d_out = 0, count = 0 throughout. First edge after release pushes 16'h00B1 → d_out = 16'h00B1, opcode = 4'h0, count = 1.
- Ordering/fill: out_ready = 0; push 16'h00B1, 16'h1131, 16'h80B1, 16'hC0B1 on 4 edges → count = 4, in_ready = 0. A 5th word, 16'hFFFF, held 2 cycles is not accepted. Then out_ready = 1 → d_out yields 00B1, 1131, 80B1, C0B1 on successive cycles, with opcodes 0, 1, 8, C. out_valid = 0 afterward.
- Streaming/wrap: in_valid = out_ready = 1 continuously for 10 words 16'h0001..16'h000A after one primed word → count stays 1, every word emerges in order exactly one cycle after its push, and pointers wrap twice.
- Full with simultaneous pop: fill to 4 with out_ready = 1 and in_valid = 1 for one cycle → pop occurs, push is refused (in_ready = 0), count = 3. Next cycle the push is accepted.
- Flush: queue holds 3 words, then flush = 1 with in_valid = 1, d_in = 16'h2222 → after the edge count = 0, out_valid = 0, 16'h2222 is dropped. The next push of 16'h3333 appears on d_out one cycle later.
- Async reset mid-stream: with count = 2, pulse rst low for 3 ns between edges → count = 0 and out_valid = 0 immediately, before the next edge.

Source files
------------

// File: rtl/ir_queue.sv
// Instruction register with a DEPTH-entry prefetch queue between fetch and decode.
// Presents the oldest word and its opcode field; flush clears the queue synchronously.
module ir_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int OPW   = 4,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out,
  output logic [OPW-1:0]   opcode,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;

  always_comb begin
    in_ready  = (cnt != CW'(DEPTH));
    out_valid = (cnt != '0);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
    d_out     = out_valid ? mem[rp] : '0;
    opcode    = d_out[WIDTH-1 -: OPW];
    count     = cnt;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else if (flush) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  // Storage is never cleared; entries outside rp..wp are unobservable.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= d_in;
  end

endmodule

// File: tb/tb_ir_queue.sv
// Bench for ir_queue: directed scenarios plus random traffic against a queue-based model.
module tb_ir_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int OPW   = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             tstclk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] d_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] d_out;
  logic [OPW-1:0]   opcode;
  logic [CW-1:0]    count;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  logic [WIDTH-1:0] q [$];

  ir_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .OPW(OPW)) dut (
    .clk(tstclk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .d_in(d_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .d_out(d_out), .opcode(opcode), .count(count)
  );

  initial tstclk = 1'b0;
  always #5 tstclk = ~tstclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [WIDTH-1:0] exp_d;
    exp_d = (q.size() > 0) ? q[0] : '0;
    check("count", 32'(count), 32'(q.size()));
    check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("d_out", 32'(d_out), 32'(exp_d));
    check("opcode", 32'(opcode), 32'(exp_d[WIDTH-1 -: OPW]));
  endtask

  // Apply inputs for one edge, advance the model by the handshake rules, then compare.
  task automatic cycle(input logic iv, input logic [WIDTH-1:0] di,
                       input logic ordy, input logic fl);
    bit do_push, do_pop;
    in_valid = iv; d_in = di; out_ready = ordy; flush = fl;
    do_push = iv && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() > 0);
    @(posedge tstclk);
    if (fl) q.delete();
    else begin
      if (do_pop)  void'(q.pop_front());
      if (do_push) q.push_back(di);
    end
    #1;
    check_all();
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; d_in = 16'h00B1; out_ready = 1'b0;
    // Reset held across three edges with a word offered.
    for (int i = 0; i < 3; i++) begin
      @(posedge tstclk);
      #1;
      check_all();
      check("rst_in_ready", 32'(in_ready), 32'd1);
    end
    #3 rst = 1'b1;
    cycle(1'b1, 16'h00B1, 1'b0, 1'b0);
    check("first_push", 32'(d_out), 32'h00B1);

    // Fill and ordering
    cycle(1'b1, 16'h1131, 1'b0, 1'b0);
    cycle(1'b1, 16'h80B1, 1'b0, 1'b0);
    cycle(1'b1, 16'hC0B1, 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 16'hFFFF, 1'b0, 1'b0);
    cycle(1'b1, 16'hFFFF, 1'b0, 1'b0);
    check("drain_op0", 32'(opcode), 32'h0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    check("drain_op1", 32'(opcode), 32'h1);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    check("drain_op8", 32'(opcode), 32'h8);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    check("drain_opC", 32'(opcode), 32'hC);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    check("empty_valid", 32'(out_valid), 32'd0);

    // Streaming across pointer wrap
    cycle(1'b1, 16'h0100, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 16'(i), 1'b1, 1'b0);
      check("stream_count", 32'(count), 32'd1);
    end
    check("stream_last", 32'(d_out), 32'h000A);

    // Full with simultaneous pop: push refused, pop happens
    cycle(1'b1, 16'h0B0B, 1'b0, 1'b0);
    cycle(1'b1, 16'h0C0C, 1'b0, 1'b0);
    cycle(1'b1, 16'h0D0D, 1'b0, 1'b0);
    cycle(1'b1, 16'h5555, 1'b1, 1'b0);
    check("fullpop_count", 32'(count), 32'd3);
    cycle(1'b1, 16'h5555, 1'b0, 1'b0);
    check("fullpop_refill", 32'(count), 32'd4);

    // Flush drops the offered word
    cycle(1'b0, 16'h0, 1'b1, 1'b0);
    cycle(1'b1, 16'h2222, 1'b0, 1'b1);
    check("flush_count", 32'(count), 32'd0);
    cycle(1'b1, 16'h3333, 1'b0, 1'b0);
    check("post_flush", 32'(d_out), 32'h3333);

    // Asynchronous reset between edges
    cycle(1'b1, 16'h4444, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #2;
    check("async_count", 32'(count), 32'd0);
    check("async_valid", 32'(out_valid), 32'd0);
    q.delete();
    #1 rst = 1'b1;

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 16'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
